// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch sequencer and its buttons / digit chain.
// STOPWATCH_LAP_EN adds the lap button and display-freeze signals.
interface stopwatch_ctrl_if;
  logic btn_ss;
  logic btn_clr;
  logic mode_up;
  logic at_zero;
  logic start;
  logic ups;
  logic clr;
  logic running;
  logic done;
`ifdef STOPWATCH_LAP_EN
  logic btn_lap;
  logic freeze;

  modport master (
    input  btn_ss, btn_clr, mode_up, at_zero, btn_lap,
    output start, ups, clr, running, done, freeze
  );

  modport slave (
    output btn_ss, btn_clr, mode_up, at_zero, btn_lap,
    input  start, ups, clr, running, done, freeze
  );
`else
  modport master (
    input  btn_ss, btn_clr, mode_up, at_zero,
    output start, ups, clr, running, done
  );

  modport slave (
    output btn_ss, btn_clr, mode_up, at_zero,
    input  start, ups, clr, running, done
  );
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the stopwatch digit chain; all outputs registered.
// Optional lap/freeze feature is enabled with STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  localparam logic [CNT_W-1:0] PrescMax = CNT_W'(TICK_DIV - 1);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_presc, w_presc_d;
  logic             r_btn_ss, r_btn_clr;
  logic             r_start, w_start_d;
  logic             r_ups, w_ups_d;
  logic             r_clr, w_clr_d;
  logic             r_running, r_done;
  logic             w_ss_rise, w_clr_rise;

  assign w_ss_rise  = bus.btn_ss & ~r_btn_ss;
  assign w_clr_rise = bus.btn_clr & ~r_btn_clr;

  always_comb begin
    w_state_d = r_state;
    w_presc_d = r_presc;
    w_start_d = 1'b0;
    w_ups_d   = r_ups;
    w_clr_d   = 1'b0;
    case (r_state)
      StIdle: begin
        w_ups_d   = bus.mode_up;
        w_presc_d = '0;
        if (w_clr_rise) begin
          w_clr_d = 1'b1;
        end else if (w_ss_rise && !(!bus.mode_up && bus.at_zero)) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (w_clr_rise) begin
          w_state_d = StIdle;
          w_clr_d   = 1'b1;
          w_presc_d = '0;
        end else if (w_ss_rise) begin
          w_state_d = StPause;
        end else if (!r_ups && bus.at_zero && !r_start) begin
          // Countdown reached zero between ticks: stop before wrapping below zero.
          w_state_d = StDone;
        end else if (r_presc == PrescMax) begin
          w_presc_d = '0;
          w_start_d = 1'b1;
        end else begin
          w_presc_d = r_presc + CNT_W'(1);
        end
      end
      StPause: begin
        if (w_clr_rise) begin
          w_state_d = StIdle;
          w_clr_d   = 1'b1;
          w_presc_d = '0;
        end else if (w_ss_rise) begin
          w_state_d = StRun;
        end
      end
      StDone: begin
        w_presc_d = '0;
        if (w_clr_rise) begin
          w_state_d = StIdle;
          w_clr_d   = 1'b1;
        end else if (w_ss_rise) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_presc   <= '0;
      r_btn_ss  <= 1'b0;
      r_btn_clr <= 1'b0;
      r_start   <= 1'b0;
      r_ups     <= 1'b1;
      r_clr     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_presc   <= w_presc_d;
      r_btn_ss  <= bus.btn_ss;
      r_btn_clr <= bus.btn_clr;
      r_start   <= w_start_d;
      r_ups     <= w_ups_d;
      r_clr     <= w_clr_d;
      r_running <= (w_state_d == StRun);
      r_done    <= (w_state_d == StDone);
    end
  end

  assign bus.start   = r_start;
  assign bus.ups     = r_ups;
  assign bus.clr     = r_clr;
  assign bus.running = r_running;
  assign bus.done    = r_done;

`ifdef STOPWATCH_LAP_EN
  logic r_btn_lap;
  logic r_freeze, w_freeze_d;

  always_comb begin
    w_freeze_d = r_freeze;
    if ((bus.btn_lap & ~r_btn_lap) && (r_state == StRun || r_state == StPause)) begin
      w_freeze_d = ~r_freeze;
    end
    if (w_state_d == StIdle) begin
      w_freeze_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_lap <= 1'b0;
      r_freeze  <= 1'b0;
    end else begin
      r_btn_lap <= bus.btn_lap;
      r_freeze  <= w_freeze_d;
    end
  end

  assign bus.freeze = r_freeze;
`endif

endmodule
